// File: rtl/rv_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Keeps datapath width and PC arithmetic in one place for fetch and its neighbours.
package rv_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef logic [XLEN-1:0] word_t;

  // Clear the byte-offset bits so any target lands on an instruction boundary.
  function automatic word_t align_pc(input word_t addr);
    return addr & ~(PC_STEP - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory address/data, execute redirect and the
// valid/ready delivery channel towards decode.
interface fetch_stage_if;
  import rv_fetch_pkg::*;

  word_t imem_addr;
  word_t imem_rdata;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  out_valid;
  logic  out_ready;
  word_t out_pc;
  word_t out_instr;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface

// File: rtl/fetch_stage_hold_buf.sv
// Single-entry skid buffer for the fetch stage: captures the in-flight word when
// decode stalls, drains it when decode accepts, and is discarded on flush.
module fetch_hold_buf
  import rv_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  capture,
  input  logic  drain,
  input  word_t cap_pc,
  input  word_t cap_instr,
  output logic  hold_valid,
  output word_t hold_pc,
  output word_t hold_instr
);

  logic  hold_valid_q, hold_valid_d;
  word_t hold_pc_q,    hold_pc_d;
  word_t hold_instr_q, hold_instr_d;

  // Flush beats drain beats capture; capture is only requested while empty.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (drain) begin
      hold_valid_d = 1'b0;
    end else if (capture) begin
      hold_valid_d = 1'b1;
      hold_pc_d    = cap_pc;
      hold_instr_d = cap_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign hold_valid = hold_valid_q;
  assign hold_pc    = hold_pc_q;
  assign hold_instr = hold_instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, pairs each synchronous memory word with its
// address and hands it to decode, absorbing back-pressure and execute redirects.
module fetch_stage
  import rv_fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  word_t pc_q,         pc_d;
  logic  infl_valid_q, infl_valid_d;
  word_t infl_pc_q,    infl_pc_d;

  logic  hold_valid;
  word_t hold_pc;
  word_t hold_instr;

  logic  out_valid;
  word_t out_pc;
  word_t out_instr;
  logic  issue_en;
  logic  hold_capture;
  logic  hold_drain;

  // The held word is always older than anything in flight, so it goes first.
  always_comb begin
    if (hold_valid) begin
      out_valid = 1'b1;
      out_pc    = hold_pc;
      out_instr = hold_instr;
    end else begin
      out_valid = infl_valid_q;
      out_pc    = infl_pc_q;
      out_instr = bus.imem_rdata;
    end
  end

  assign issue_en     = bus.out_ready | ~out_valid;
  assign hold_capture = ~issue_en & infl_valid_q & ~hold_valid;
  assign hold_drain   = hold_valid & bus.out_ready;

  // The memory has no read enable; on a stall the address is simply re-issued
  // later and the word returned meanwhile is marked invalid.
  always_comb begin
    pc_d         = pc_q;
    infl_valid_d = infl_valid_q;
    infl_pc_d    = infl_pc_q;
    if (bus.redirect_valid) begin
      pc_d         = align_pc(bus.redirect_pc);
      infl_valid_d = 1'b0;
    end else if (issue_en) begin
      infl_valid_d = 1'b1;
      infl_pc_d    = pc_q;
      pc_d         = pc_q + PC_STEP;
    end else begin
      infl_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_valid),
    .capture    (hold_capture),
    .drain      (hold_drain),
    .cap_pc     (infl_pc_q),
    .cap_instr  (bus.imem_rdata),
    .hold_valid (hold_valid),
    .hold_pc    (hold_pc),
    .hold_instr (hold_instr)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_pc;
  assign bus.out_instr = out_instr;

endmodule
